jam_cost_server: RTL

JAM_COST_SERVER -- requirements
Module: jam_cost_server

---
 rtl/jam_pkg.sv | 29 ++
 rtl/jam_cost_table.sv | 32 +++
 rtl/jam_cost_server.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost server and the JAM engine it feeds.
// Holds the FSM state encoding, the table and result widths, the default
// SERVE-state timeout, and the helper that turns (worker, job) into a
// row-major table index.
package jam_pkg;

  localparam int TABLE_DEPTH            = 64;
  localparam int COST_W                 = 7;
  localparam int MIN_W                  = 10;
  localparam int CNT_W                  = 4;
  localparam int IDX_W                  = 6;
  localparam int SEL_W                  = 3;
  localparam int CTR_W                  = 17;
  localparam int DEFAULT_TIMEOUT_CYCLES = 45000;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SERVE   = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Row-major index: worker selects the row of 8, job selects the column.
  function automatic logic [IDX_W-1:0] table_index(input logic [SEL_W-1:0] w,
                                                   input logic [SEL_W-1:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_cost_table.sv
// 64 x 7-bit cost register file.
// Ports:
//   CLK    clock
//   we     write enable (synchronous write on rising edge)
//   waddr  write index
//   wdata  cost word to store
//   raddr  read index
//   rdata  cost word at raddr, combinational
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [TABLE_DEPTH];

  // NOTE: the storage array is deliberately not reset; every run reloads all
  // 64 words before the engine is released, so clearing it would buy nothing.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // The engine samples Cost on the falling edge, so the read path must be
  // purely combinational.
  assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table server for the JAM assignment engine.
// Loads a 64-word cost table, releases the engine from reset, serves cost
// lookups, and captures the engine's result (or aborts on a cycle limit),
// comparing it against the expected values.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   load_valid/load_data   cost word stream, row-major (W*8+J)
//   load_ready             high while words are accepted
//   jam_rst                reset to the engine, high until the table is loaded
//   W, J, Cost             engine lookup of cost[W][J]
//   Valid, MinCost,
//   MatchCount             engine result
//   exp_min, exp_cnt       expected result, sampled on the capture edge
//   done, pass, timeout    run status, frozen once done
//   got_min, got_cnt       captured result
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              jam_rst,
  input  logic [SEL_W-1:0]  W,
  input  logic [SEL_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [MIN_W-1:0]  MinCost,
  input  logic [CNT_W-1:0]  MatchCount,
  input  logic [MIN_W-1:0]  exp_min,
  input  logic [CNT_W-1:0]  exp_cnt,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [MIN_W-1:0]  got_min,
  output logic [CNT_W-1:0]  got_cnt
);

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CTR_W)) begin : g_bad_timeout
      $error("jam_cost_server: TIMEOUT_CYCLES must be in 1 .. 2**17-1");
    end
  endgenerate

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [CTR_W-1:0]  ctr;
  logic              load_we;

  assign load_we = (state == ST_LOAD) && load_valid;

  // Writes are suppressed during RST so a reset cycle never lands a stray word.
  jam_cost_table u_table (
    .CLK   (CLK),
    .we    (load_we && !RST),
    .waddr (idx),
    .wdata (load_data),
    .raddr (table_index(W, J)),
    .rdata (Cost)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_LOAD:    if (load_we && idx == IDX_LAST) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_SERVE;
      ST_SERVE:   if (Valid || ctr == CTR_LAST) state_nxt = ST_FINISH;
      ST_FINISH:  state_nxt = ST_FINISH;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  // Moore outputs.
  always_comb begin
    load_ready = (state == ST_LOAD);
    jam_rst    = (state == ST_LOAD) || (state == ST_RELEASE);
    done       = (state == ST_FINISH);
  end

  // Load index, SERVE cycle counter and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx     <= '0;
      ctr     <= '0;
      pass    <= 1'b0;
      timeout <= 1'b0;
      got_min <= '0;
      got_cnt <= '0;
    end else begin
      // idx wraps to 0 after the 64th word.
      if (load_we) idx <= idx + 1'b1;

      if (state == ST_SERVE) begin
        ctr <= ctr + 1'b1;
        // A result arriving on the limit edge takes priority over the abort.
        if (Valid) begin
          got_min <= MinCost;
          got_cnt <= MatchCount;
          pass    <= (MinCost == exp_min) && (MatchCount == exp_cnt);
          timeout <= 1'b0;
        end else if (ctr == CTR_LAST) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
        end
      end else begin
        ctr <= '0;
      end
    end
  end

endmodule
